// File: rtl/procesador_frames_estado_in_if.sv
// Avalon-MM slave bus bundle for the frame-status input port.
// Handshake: a write happens on a rising clk when chipselect=1 and write_n=0;
// reads have no strobe -- readdata always returns the addressed register one cycle later.
interface procesador_frames_estado_in_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );
endinterface

// File: rtl/procesador_frames_estado_in.sv
// Status input port: synchronises fabric flags, captures per-bit edges, counts
// frame-done events on bit 0 and raises a maskable level interrupt.
module procesador_frames_estado_in #(
    parameter int unsigned      WIDTH          = 16,
    parameter int unsigned      EDGE_TYPE      = 0,
    parameter logic [WIDTH-1:0] IRQ_RESET_MASK = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port,
    procesador_frames_estado_in_if.slave avs
);

    logic [WIDTH-1:0] sync1_q, sync2_q, prev_q;
    logic [WIDTH-1:0] edgecapture_q, edgecapture_d;
    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic [31:0]      event_count_q, event_count_d;
    logic [31:0]      readdata_q, readdata_d;
    logic [1:0]       arm_cnt_q;
    logic [WIDTH-1:0] edges;
    logic             wr_en;
    logic             unused_wd;

    assign wr_en     = avs.chipselect & ~avs.write_n;
    assign unused_wd = ^avs.writedata;

    // Gated until the pipeline holds only post-reset samples, so high-at-reset levels never look like edges.
    always_comb begin
        edges = '0;
        if (arm_cnt_q == 2'd3) begin
            if (EDGE_TYPE == 0) begin
                edges = sync2_q & ~prev_q;
            end else if (EDGE_TYPE == 1) begin
                edges = ~sync2_q & prev_q;
            end else begin
                edges = sync2_q ^ prev_q;
            end
        end
    end

    always_comb begin
        event_count_d = event_count_q + {31'd0, edges[0]};
        irqmask_d     = irqmask_q;
        edgecapture_d = edgecapture_q | edges;
        if (wr_en) begin
            case (avs.address)
                2'd1:    event_count_d = {31'd0, edges[0]};
                2'd2:    irqmask_d     = avs.writedata[WIDTH-1:0];
                2'd3:    edgecapture_d = (edgecapture_q & ~avs.writedata[WIDTH-1:0]) | edges;
                default: ;
            endcase
        end
        readdata_d = 32'd0;
        case (avs.address)
            2'd0:    readdata_d = 32'(sync2_q);
            2'd1:    readdata_d = event_count_q;
            2'd2:    readdata_d = 32'(irqmask_q);
            default: readdata_d = 32'(edgecapture_q);
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            prev_q        <= '0;
            edgecapture_q <= '0;
            irqmask_q     <= IRQ_RESET_MASK;
            event_count_q <= '0;
            readdata_q    <= '0;
            arm_cnt_q     <= '0;
        end else begin
            sync1_q       <= in_port;
            sync2_q       <= sync1_q;
            prev_q        <= sync2_q;
            edgecapture_q <= edgecapture_d;
            irqmask_q     <= irqmask_d;
            event_count_q <= event_count_d;
            readdata_q    <= readdata_d;
            if (arm_cnt_q != 2'd3) begin
                arm_cnt_q <= arm_cnt_q + 2'd1;
            end
        end
    end

    assign avs.readdata = readdata_q;
    assign avs.irq      = |(edgecapture_q & irqmask_q);

endmodule

// File: tb/tb_procesador_frames_estado_in.sv
// Bench for procesador_frames_estado_in: two instances (rising-edge and any-edge)
// share one bus stimulus and are compared each cycle against a delay-line model.
module tb_procesador_frames_estado_in;
    localparam int W = 16;
    localparam logic [W-1:0] RST_MASK0 = 16'h8001;
    localparam logic [W-1:0] RST_MASK2 = 16'h0000;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [W-1:0] in_port = '1;
    int           checks = 0;
    int           failures = 0;
    logic [31:0]  r0, r2;

    procesador_frames_estado_in_if bus0 ();
    procesador_frames_estado_in_if bus2 ();

    procesador_frames_estado_in #(.WIDTH(W), .EDGE_TYPE(0), .IRQ_RESET_MASK(RST_MASK0)) dut0 (
        .clk     (clk),
        .reset_n (reset_n),
        .in_port (in_port),
        .avs     (bus0)
    );

    procesador_frames_estado_in #(.WIDTH(W), .EDGE_TYPE(2), .IRQ_RESET_MASK(RST_MASK2)) dut2 (
        .clk     (clk),
        .reset_n (reset_n),
        .in_port (in_port),
        .avs     (bus2)
    );

    // ---------------- clock ----------------
    initial forever #5 clk = ~clk;

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // m_seen[i][k] is in_port as sampled k clock edges ago (zeroed by reset).
    logic [W-1:0] m_seen [2][3];
    logic [W-1:0] m_cap  [2];
    logic [W-1:0] m_mask [2];
    logic [31:0]  m_cnt  [2];
    logic [31:0]  m_rd   [2];
    int           m_since = 0;
    bit           m_live = 1'b0;

    always @(posedge clk) begin
        logic         wr;
        logic [W-1:0] wd, now_lvl, old_lvl, e;
        wr = bus0.chipselect && !bus0.write_n;
        wd = bus0.writedata[W-1:0];
        for (int i = 0; i < 2; i++) begin
            if (!reset_n) begin
                for (int k = 0; k < 3; k++) m_seen[i][k] = '0;
                m_cap[i]  = '0;
                m_cnt[i]  = '0;
                m_rd[i]   = '0;
                m_mask[i] = (i == 0) ? RST_MASK0 : RST_MASK2;
            end else begin
                now_lvl = m_seen[i][1];
                old_lvl = m_seen[i][2];
                case (bus0.address)
                    2'd0: m_rd[i] = {16'd0, now_lvl};
                    2'd1: m_rd[i] = m_cnt[i];
                    2'd2: m_rd[i] = {16'd0, m_mask[i]};
                    default: m_rd[i] = {16'd0, m_cap[i]};
                endcase
                e = '0;
                if (m_since >= 3) begin
                    for (int b = 0; b < W; b++) begin
                        if (i == 0) e[b] = (now_lvl[b] == 1'b1) && (old_lvl[b] == 1'b0);
                        else        e[b] = (now_lvl[b] != old_lvl[b]);
                    end
                end
                if (wr && bus0.address == 2'd1) m_cnt[i] = e[0] ? 32'd1 : 32'd0;
                else                            m_cnt[i] = m_cnt[i] + (e[0] ? 32'd1 : 32'd0);
                if (wr && bus0.address == 2'd2) m_mask[i] = wd;
                if (wr && bus0.address == 2'd3) m_cap[i] = m_cap[i] & ~wd;
                m_cap[i] = m_cap[i] | e;
                m_seen[i][2] = m_seen[i][1];
                m_seen[i][1] = m_seen[i][0];
                m_seen[i][0] = in_port;
            end
        end
        m_since = reset_n ? m_since + 1 : 0;
        m_live  = 1'b1;
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (m_live) begin
            check("rd_et0",  bus0.readdata, m_rd[0]);
            check("irq_et0", {31'd0, bus0.irq}, {31'd0, |(m_cap[0] & m_mask[0])});
            check("rd_et2",  bus2.readdata, m_rd[1]);
            check("irq_et2", {31'd0, bus2.irq}, {31'd0, |(m_cap[1] & m_mask[1])});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [1:0] a, input logic cs, input logic wn, input logic [31:0] wd);
        bus0.address = a; bus0.chipselect = cs; bus0.write_n = wn; bus0.writedata = wd;
        bus2.address = a; bus2.chipselect = cs; bus2.write_n = wn; bus2.writedata = wd;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
        drive(a, 1'b1, 1'b0, d);
        tick(1);
        drive(a, 1'b0, 1'b1, 32'd0);
    endtask

    task automatic rd_reg(input logic [1:0] a, output logic [31:0] v0, output logic [31:0] v2);
        drive(a, 1'b1, 1'b1, 32'd0);
        tick(1);
        v0 = bus0.readdata;
        v2 = bus2.readdata;
        drive(a, 1'b0, 1'b1, 32'd0);
    endtask

    task automatic check_irq(input string name, input logic e0, input logic e2);
        check({name, "_et0"}, {31'd0, bus0.irq}, {31'd0, e0});
        check({name, "_et2"}, {31'd0, bus2.irq}, {31'd0, e2});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        drive(2'd0, 1'b0, 1'b1, 32'd0);

        // reset held 3 edges with all inputs high
        tick(3);
        reset_n = 1'b1;
        check("rst_rd_et0", bus0.readdata, 32'd0);
        check("rst_rd_et2", bus2.readdata, 32'd0);
        check_irq("rst_irq", 1'b0, 1'b0);
        tick(6);
        rd_reg(2'd0, r0, r2);
        check("rst_data_et0", r0, 32'h0000_FFFF);
        check("rst_data_et2", r2, 32'h0000_FFFF);
        rd_reg(2'd3, r0, r2);
        check("rst_nocap_et0", r0, 32'd0);
        check("rst_nocap_et2", r2, 32'd0);
        rd_reg(2'd2, r0, r2);
        check("rst_mask_et0", r0, 32'h0000_8001);
        check("rst_mask_et2", r2, 32'h0000_0000);

        // latency: change before edge E, capture and irq at E+2
        in_port = '0;
        tick(4);
        wr_reg(2'd3, 32'hFFFF);
        wr_reg(2'd1, 32'd0);
        wr_reg(2'd2, 32'h0001);
        in_port[0] = 1'b1;
        tick(1); check_irq("lat_e0", 1'b0, 1'b0);
        tick(1); check_irq("lat_e1", 1'b0, 1'b0);
        tick(1); check_irq("lat_e2", 1'b1, 1'b1);
        rd_reg(2'd3, r0, r2);
        check("lat_cap_et0", r0, 32'h1);
        check("lat_cap_et2", r2, 32'h1);
        rd_reg(2'd1, r0, r2);
        check("lat_cnt_et0", r0, 32'd1);
        check("lat_cnt_et2", r2, 32'd1);

        // write-1-to-clear
        wr_reg(2'd3, 32'h1);
        check_irq("clr_irq", 1'b0, 1'b0);
        rd_reg(2'd3, r0, r2);
        check("clr_cap_et0", r0, 32'd0);
        check("clr_cap_et2", r2, 32'd0);

        // clear landing in the same cycle as a new edge: set wins
        in_port[0] = 1'b0;
        tick(4);
        wr_reg(2'd3, 32'hFFFF);
        in_port[0] = 1'b1;
        tick(2);
        wr_reg(2'd3, 32'h1);
        check_irq("setwin_irq", 1'b1, 1'b1);
        rd_reg(2'd3, r0, r2);
        check("setwin_cap_et0", r0, 32'h1);
        check("setwin_cap_et2", r2, 32'h1);

        // five pulses on bit 0
        wr_reg(2'd1, 32'd0);
        for (int p = 0; p < 5; p++) begin
            in_port[0] = 1'b0; tick(3);
            in_port[0] = 1'b1; tick(3);
        end
        tick(2);
        rd_reg(2'd1, r0, r2);
        check("cnt5_et0", r0, 32'd5);
        check("cnt5_et2", r2, 32'd10);

        // wrap from all-ones
        in_port[0] = 1'b0;
        tick(4);
        dut0.event_count_q = 32'hFFFF_FFFF;
        dut2.event_count_q = 32'hFFFF_FFFF;
        m_cnt[0] = 32'hFFFF_FFFF;
        m_cnt[1] = 32'hFFFF_FFFF;
        in_port[0] = 1'b1;
        tick(4);
        rd_reg(2'd1, r0, r2);
        check("wrap_et0", r0, 32'd0);
        check("wrap_et2", r2, 32'd0);

        // count write colliding with an edge
        in_port[0] = 1'b0;
        tick(4);
        in_port[0] = 1'b1;
        tick(2);
        wr_reg(2'd1, 32'h1234);
        rd_reg(2'd1, r0, r2);
        check("cntwr_edge_et0", r0, 32'd1);
        check("cntwr_edge_et2", r2, 32'd1);

        // masked capture, then unmask
        wr_reg(2'd2, 32'h0);
        wr_reg(2'd3, 32'hFFFF);
        in_port[5] = 1'b1;
        tick(4);
        rd_reg(2'd3, r0, r2);
        check("mask_cap_et0", r0, 32'h0020);
        check("mask_cap_et2", r2, 32'h0020);
        check_irq("mask_irq_off", 1'b0, 1'b0);
        in_port[5] = 1'b0;
        tick(4);
        check_irq("mask_irq_off2", 1'b0, 1'b0);
        wr_reg(2'd2, 32'h0020);
        check_irq("mask_irq_on", 1'b1, 1'b1);
        wr_reg(2'd2, 32'h0000);
        check_irq("mask_irq_drop", 1'b0, 1'b0);

        // randomized traffic, occasional reset
        for (int c = 0; c < 600; c++) begin
            reset_n = ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 2) == 0)
                in_port = in_port ^ (16'(1) << $urandom_range(0, W - 1));
            if ($urandom_range(0, 49) == 0)
                in_port = 16'($urandom);
            drive(2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 1) == 0), $urandom);
            tick(1);
        end
        reset_n = 1'b1;
        drive(2'd0, 1'b0, 1'b1, 32'd0);

        // reset in the middle of activity
        in_port = '0;
        tick(6);
        wr_reg(2'd3, 32'hFFFF);
        wr_reg(2'd1, 32'd0);
        wr_reg(2'd2, 32'h0020);
        in_port = 16'h00FF;
        tick(3);
        for (int p = 0; p < 6; p++) begin
            in_port = 16'h00FE; tick(3);
            in_port = 16'h00FF; tick(3);
        end
        tick(1);
        rd_reg(2'd3, r0, r2);
        check("mid_cap_et0", r0, 32'h00FF);
        check("mid_cap_et2", r2, 32'h00FF);
        rd_reg(2'd1, r0, r2);
        check("mid_cnt_et0", r0, 32'd7);
        check("mid_cnt_et2", r2, 32'd13);
        check_irq("mid_irq", 1'b1, 1'b1);
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        check("mid_rst_rd_et0", bus0.readdata, 32'd0);
        check("mid_rst_rd_et2", bus2.readdata, 32'd0);
        check_irq("mid_rst_irq", 1'b0, 1'b0);
        rd_reg(2'd3, r0, r2);
        check("mid_rst_cap_et0", r0, 32'd0);
        check("mid_rst_cap_et2", r2, 32'd0);
        rd_reg(2'd1, r0, r2);
        check("mid_rst_cnt_et0", r0, 32'd0);
        check("mid_rst_cnt_et2", r2, 32'd0);
        rd_reg(2'd2, r0, r2);
        check("mid_rst_mask_et0", r0, 32'h0000_8001);
        check("mid_rst_mask_et2", r2, 32'h0000_0000);
        rd_reg(2'd0, r0, r2);
        check("mid_rst_data_et0", r0, 32'h0000_00FF);
        check("mid_rst_data_et2", r2, 32'h0000_00FF);
        tick(6);
        rd_reg(2'd3, r0, r2);
        check("mid_rst_nocap_et0", r0, 32'd0);
        check("mid_rst_nocap_et2", r2, 32'd0);
        tick(2);

        // ---------------- report ----------------
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
